// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// UartReceiver (module uart_receiver)
//
// Purpose:
//   8N1 UART receiver, LSB first, idle-high line. The serial input is brought
//   into the clock domain through a two-flop synchronizer, then a five-state
//   FSM finds the start bit, samples each data bit mid-bit and checks the stop
//   bit. Completed bytes are presented on a valid/ack holding register.
//   Framing and overrun errors are sticky until cleared.
//
// Parameters:
//   CLK_FREQ_HZ      system clock frequency in Hz
//   BAUD_RATE        serial bit rate
//
// Ports:
//   i_clk            system clock, all state changes on the rising edge
//   i_reset          asynchronous, active-high reset
//   i_uart_rx        asynchronous serial line (idle high)
//   o_rx_data        last accepted byte, held until replaced
//   o_rx_valid       high while o_rx_data holds an unacknowledged byte
//   i_rx_ack         one-cycle read acknowledge, clears o_rx_valid
//   i_clear_errors   one-cycle pulse, clears both sticky error flags
//   o_framing_error  sticky: a stop bit was sampled low
//   o_overrun_error  sticky: a byte completed while the previous one was unread
//   o_busy           high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ack,
  input  logic       i_clear_errors,
  output logic       o_framing_error,
  output logic       o_overrun_error,
  output logic       o_busy
);

  localparam int DATA_WIDTH   = 8;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  // The bit-period counter only ever has to hold CLKS_PER_BIT-1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] BIT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST     = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);

  // Fewer than four clocks per bit leaves no usable mid-bit sample point.
  generate
    if (CLKS_PER_BIT < 4) begin : g_badBaudRatio
      $error("uart_receiver: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rxState_t;

  logic                  r_syncMeta;
  logic                  r_rxSync;

  rxState_t              r_state;
  rxState_t              w_stateNext;
  logic [CNT_W-1:0]      r_clkCount;
  logic [CNT_W-1:0]      w_clkCountNext;
  logic [BIT_W-1:0]      r_bitCount;
  logic [BIT_W-1:0]      w_bitCountNext;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shiftNext;

  logic                  w_commit;
  logic                  w_frameErr;

  logic [DATA_WIDTH-1:0] r_rxData;
  logic                  r_rxValid;
  logic                  r_framingError;
  logic                  r_overrunError;

  // Two-flop synchronizer. Both flops reset high so that reset itself never
  // looks like a falling edge on the idle line.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_syncMeta <= 1'b1;
      r_rxSync   <= 1'b1;
    end else begin
      r_syncMeta <= i_uart_rx;
      r_rxSync   <= r_syncMeta;
    end
  end

  // FSM state and datapath registers. Everything here is computed by the
  // next-state block below and simply registered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_clkCount <= '0;
      r_bitCount <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_clkCount <= w_clkCountNext;
      r_bitCount <= w_bitCountNext;
      r_shift    <= w_shiftNext;
    end
  end

  // Next-state logic. The start bit is re-checked half a bit after the
  // falling edge, so every later sample is one full bit period apart and
  // lands mid-bit. A low stop bit means a break or a bad frame; the receiver
  // then parks in WAIT_HIGH so the still-low line is not mistaken for a start.
  always_comb begin
    w_stateNext    = r_state;
    w_clkCountNext = r_clkCount;
    w_bitCountNext = r_bitCount;
    w_shiftNext    = r_shift;
    w_commit       = 1'b0;
    w_frameErr     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!r_rxSync) begin
          w_stateNext    = START;
          w_clkCountNext = '0;
          w_bitCountNext = '0;
        end
      end

      START: begin
        if (r_clkCount == HALF_LAST) begin
          w_clkCountNext = '0;
          if (!r_rxSync) begin
            w_stateNext = DATA;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_clkCountNext = r_clkCount + 1'b1;
        end
      end

      DATA: begin
        if (r_clkCount == BIT_LAST) begin
          w_clkCountNext = '0;
          w_shiftNext    = {r_rxSync, r_shift[DATA_WIDTH-1:1]};
          w_bitCountNext = r_bitCount + 1'b1;
          if (r_bitCount == LAST_DATA_BIT) begin
            w_stateNext = STOP;
          end
        end else begin
          w_clkCountNext = r_clkCount + 1'b1;
        end
      end

      STOP: begin
        if (r_clkCount == BIT_LAST) begin
          w_clkCountNext = '0;
          if (r_rxSync) begin
            w_commit    = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_frameErr  = 1'b1;
            w_stateNext = WAIT_HIGH;
          end
        end else begin
          w_clkCountNext = r_clkCount + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (r_rxSync) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext    = IDLE;
        w_clkCountNext = '0;
        w_bitCountNext = '0;
      end
    endcase
  end

  // Holding register. A new byte replaces the old one only if the old one
  // has been read or is being read in this very cycle; otherwise the new
  // byte is dropped and the overrun flag records the loss.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else if (w_commit) begin
      if (!r_rxValid || i_rx_ack) begin
        r_rxData  <= r_shift;
        r_rxValid <= 1'b1;
      end
    end else if (i_rx_ack) begin
      r_rxValid <= 1'b0;
    end
  end

  // Sticky error flags. A new error in the same cycle as a clear request
  // takes priority, so no event is ever silently lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_framingError <= 1'b0;
      r_overrunError <= 1'b0;
    end else begin
      r_framingError <= (r_framingError & ~i_clear_errors) | w_frameErr;
      r_overrunError <= (r_overrunError & ~i_clear_errors)
                        | (w_commit & r_rxValid & ~i_rx_ack);
    end
  end

  assign o_rx_data       = r_rxData;
  assign o_rx_valid      = r_rxValid;
  assign o_framing_error = r_framingError;
  assign o_overrun_error = r_overrunError;
  assign o_busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Self-checking bench for uart_receiver at 16 clocks per bit. A table of
// frames exercises the normal path; hand-written sequences cover latency,
// glitch rejection, break/framing handling, overrun and reset mid-frame.
// Every byte expected to be accepted is queued when its frame is driven and
// matched by a monitor whenever the DUT presents a new byte.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CLK_FREQ_HZ = 1_600_000;
  localparam int BAUD_RATE   = 100_000;
  localparam int CPB         = 16;
  localparam int LATENCY     = CPB / 2 + 9 * CPB + 3;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       expValid;
    logic       expFrameErr;
  } frameVec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uartRx = 1'b1;
  logic       rxAck = 1'b0;
  logic       clearErrors = 1'b0;
  logic [7:0] rxData;
  logic       rxValid;
  logic       framingError;
  logic       overrunError;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         latency;
  logic [7:0] expectedQ[$];
  logic [7:0] expByte;
  logic       prevValid = 1'b0;
  logic [7:0] prevData = 8'h00;
  frameVec_t  vectors[8];

  // 10 ns system clock.
  always #5 clock = ~clock;

  uart_receiver #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .i_clk          (clock),
    .i_reset        (reset),
    .i_uart_rx      (uartRx),
    .o_rx_data      (rxData),
    .o_rx_valid     (rxValid),
    .i_rx_ack       (rxAck),
    .i_clear_errors (clearErrors),
    .o_framing_error(framingError),
    .o_overrun_error(overrunError),
    .o_busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one full frame; must be called right after a falling clock edge
  // and returns on the falling edge that ends the stop bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    uartRx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int b = 0; b < 8; b++) begin
      uartRx = data[b];
      repeat (CPB) @(negedge clock);
    end
    uartRx = stopBit;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic pulseAck();
    rxAck = 1'b1;
    @(negedge clock);
    rxAck = 1'b0;
  endtask

  task automatic pulseClear();
    clearErrors = 1'b1;
    @(negedge clock);
    clearErrors = 1'b0;
  endtask

  // Scoreboard monitor: a rising valid or a changed data byte means the DUT
  // accepted a new byte, which must match the oldest queued expectation.
  always @(posedge clock) begin
    #1;
    if (!reset && ((rxValid && !prevValid) || (rxData != prevData))) begin
      if (expectedQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got unexpected byte 0x%0h, expected none", rxData);
      end else begin
        expByte = expectedQ.pop_front();
        checkOutput("scoreboard byte", {24'h0, rxData}, {24'h0, expByte});
      end
    end
    prevValid = rxValid;
    prevData  = rxData;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vectors[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vectors[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vectors[3] = '{8'hAA, 1'b1, 1'b1, 1'b0};
    vectors[4] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vectors[5] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vectors[6] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vectors[7] = '{8'hE7, 1'b1, 1'b1, 1'b0};

    // Reset state.
    repeat (5) @(negedge clock);
    checkOutput("reset rx_data", {24'h0, rxData}, 32'h00);
    checkOutput("reset rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("reset framing_error", {31'h0, framingError}, 32'h0);
    checkOutput("reset overrun_error", {31'h0, overrunError}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("post-reset busy", {31'h0, busy}, 32'h0);

    // 0xA5 with latency measurement from the line's falling edge.
    expectedQ.push_back(8'hA5);
    latency = 0;
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        while (!rxValid && latency < 400) begin
          @(posedge clock);
          #1;
          latency++;
        end
      end
    join
    checks++;
    if (latency < LATENCY - 1 || latency > LATENCY + 1) begin
      errors++;
      $display("[TB] FAIL latency: got %0d clocks, expected %0d +/- 1", latency, LATENCY);
    end
    checkOutput("A5 rx_data", {24'h0, rxData}, 32'hA5);
    checkOutput("A5 rx_valid", {31'h0, rxValid}, 32'h1);
    pulseAck();
    checkOutput("A5 ack rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("A5 ack rx_data", {24'h0, rxData}, 32'hA5);

    // Short low glitch must be rejected at the half-bit check.
    uartRx = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("glitch busy during", {31'h0, busy}, 32'h1);
    uartRx = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("glitch busy after", {31'h0, busy}, 32'h0);
    checkOutput("glitch rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("glitch framing_error", {31'h0, framingError}, 32'h0);
    checkOutput("glitch overrun_error", {31'h0, overrunError}, 32'h0);

    // Ack while nothing is pending has no effect.
    pulseAck();
    checkOutput("idle ack rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("idle ack rx_data", {24'h0, rxData}, 32'hA5);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      if (vectors[i].expValid) expectedQ.push_back(vectors[i].data);
      applyStimulus(vectors[i].data, vectors[i].stopBit);
      uartRx = 1'b1;
      repeat (4) @(negedge clock);
      checkOutput($sformatf("vec%0d rx_valid", i), {31'h0, rxValid}, {31'h0, vectors[i].expValid});
      checkOutput($sformatf("vec%0d framing_error", i), {31'h0, framingError},
                  {31'h0, vectors[i].expFrameErr});
      checkOutput($sformatf("vec%0d overrun_error", i), {31'h0, overrunError}, 32'h0);
      checkOutput($sformatf("vec%0d busy", i), {31'h0, busy}, 32'h0);
      if (vectors[i].expValid) begin
        checkOutput($sformatf("vec%0d rx_data", i), {24'h0, rxData}, {24'h0, vectors[i].data});
        pulseAck();
      end
      pulseClear();
      checkOutput($sformatf("vec%0d cleared rx_valid", i), {31'h0, rxValid}, 32'h0);
      checkOutput($sformatf("vec%0d cleared framing_error", i), {31'h0, framingError}, 32'h0);
    end

    // Break: low stop bit with clear_errors on the same cycle, line held low.
    fork
      applyStimulus(8'h3C, 1'b0);
      begin
        repeat (LATENCY - 1) @(negedge clock);
        clearErrors = 1'b1;
        @(negedge clock);
        clearErrors = 1'b0;
      end
    join
    repeat (40) @(negedge clock);
    checkOutput("break framing_error", {31'h0, framingError}, 32'h1);
    checkOutput("break rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("break busy", {31'h0, busy}, 32'h1);
    uartRx = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("break released busy", {31'h0, busy}, 32'h0);
    expectedQ.push_back(8'h81);
    applyStimulus(8'h81, 1'b1);
    repeat (2) @(negedge clock);
    checkOutput("81 rx_data", {24'h0, rxData}, 32'h81);
    checkOutput("81 rx_valid", {31'h0, rxValid}, 32'h1);
    checkOutput("81 framing_error sticky", {31'h0, framingError}, 32'h1);
    pulseAck();
    pulseClear();
    checkOutput("81 framing_error cleared", {31'h0, framingError}, 32'h0);

    // Overrun: second byte arrives with the first unread.
    expectedQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1);
    repeat (4) @(negedge clock);
    applyStimulus(8'h22, 1'b1);
    repeat (4) @(negedge clock);
    checkOutput("overrun rx_data", {24'h0, rxData}, 32'h11);
    checkOutput("overrun rx_valid", {31'h0, rxValid}, 32'h1);
    checkOutput("overrun overrun_error", {31'h0, overrunError}, 32'h1);
    pulseClear();
    checkOutput("overrun cleared", {31'h0, overrunError}, 32'h0);
    pulseAck();
    checkOutput("overrun ack rx_valid", {31'h0, rxValid}, 32'h0);

    // Same pair, but the ack lands exactly on the commit cycle.
    expectedQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1);
    repeat (4) @(negedge clock);
    expectedQ.push_back(8'h22);
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        repeat (LATENCY - 1) @(negedge clock);
        rxAck = 1'b1;
        @(negedge clock);
        rxAck = 1'b0;
      end
    join
    repeat (2) @(negedge clock);
    checkOutput("ack-on-commit rx_data", {24'h0, rxData}, 32'h22);
    checkOutput("ack-on-commit rx_valid", {31'h0, rxValid}, 32'h1);
    checkOutput("ack-on-commit overrun_error", {31'h0, overrunError}, 32'h0);

    // Reset in the middle of data bit 4, with 0x22 still pending.
    uartRx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int b = 0; b < 4; b++) begin
      uartRx = 1'b1;
      repeat (CPB) @(negedge clock);
    end
    repeat (CPB / 2) @(negedge clock);
    checkOutput("mid-frame busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mid-frame reset rx_data", {24'h0, rxData}, 32'h00);
    checkOutput("mid-frame reset rx_valid", {31'h0, rxValid}, 32'h0);
    checkOutput("mid-frame reset busy", {31'h0, busy}, 32'h0);
    checkOutput("mid-frame reset framing_error", {31'h0, framingError}, 32'h0);
    checkOutput("mid-frame reset overrun_error", {31'h0, overrunError}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("after reset busy", {31'h0, busy}, 32'h0);
    expectedQ.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1);
    repeat (2) @(negedge clock);
    checkOutput("5A rx_data", {24'h0, rxData}, 32'h5A);
    checkOutput("5A rx_valid", {31'h0, rxValid}, 32'h1);
    checkOutput("5A framing_error", {31'h0, framingError}, 32'h0);
    checkOutput("5A overrun_error", {31'h0, overrunError}, 32'h0);

    checkOutput("scoreboard drained", expectedQ.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
